// File: rtl/timer_scheduler.sv
// Round-robin arbiter that lends one shared seconds timer to N_REQ requesters.
// Outputs are registered; a zero duration skips the timer and completes immediately.
module timer_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SEC_W = 7
) (
  input  logic                   CLK,
  input  logic                   resetCounter,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*SEC_W-1:0] req_seconds,
  input  logic [N_REQ-1:0]       cancel,
  input  logic                   timer_finished,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [SEC_W-1:0]       timer_seconds,
  output logic                   timer_start
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;

  logic             winFound;
  logic [IDX_W-1:0] winIdx;
  logic [SEC_W-1:0] winSec;
  logic [N_REQ-1:0] winOneHot;
  logic [SEC_W-1:0] secArr [N_REQ];

  // Split the flat duration bus into one field per requester.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      secArr[i] = req_seconds[i*SEC_W +: SEC_W];
    end
  end

  // Search ptr+1, ptr+2, ... ; descending loop so the nearest hit is assigned last.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((32'(ptr) + i) % N_REQ);
      if (req[cand]) begin
        winFound = 1'b1;
        winIdx   = cand;
      end
    end
    winSec    = secArr[winIdx];
    winOneHot = N_REQ'(1) << winIdx;
  end

  always_ff @(posedge CLK) begin
    if (resetCounter) begin
      state         <= IDLE;
      grant         <= '0;
      done          <= '0;
      busy          <= 1'b0;
      timer_seconds <= '0;
      timer_start   <= 1'b0;
      ptr           <= IDX_W'(N_REQ - 1);
      owner         <= '0;
    end else begin
      timer_start <= 1'b0;
      done        <= '0;
      case (state)
        IDLE: begin
          if (winFound) begin
            owner         <= winIdx;
            grant         <= winOneHot;
            busy          <= 1'b1;
            timer_seconds <= winSec;
            if (winSec != '0) begin
              state       <= START;
              timer_start <= 1'b1;
            end else begin
              state <= DONE;
              done  <= winOneHot;
            end
          end
        end
        // Timer may still report a stale completion this cycle, so it is not looked at.
        START: state <= WAIT;
        WAIT: begin
          if (timer_finished) begin
            state <= DONE;
            done  <= grant;
          end else if (cancel[owner]) begin
            state         <= IDLE;
            grant         <= '0;
            busy          <= 1'b0;
            timer_seconds <= '0;
            ptr           <= owner;
          end
        end
        DONE: begin
          state         <= IDLE;
          grant         <= '0;
          busy          <= 1'b0;
          timer_seconds <= '0;
          ptr           <= owner;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed and randomized bench for timer_scheduler against a transaction-level
// reference model of the owner / round-robin rules.
module tb_timer_scheduler;

  logic        CLK = 1'b0;
  logic        resetCounter;
  logic [3:0]  req;
  logic [27:0] reqSeconds;
  logic [3:0]  cancel;
  logic        timerFinished;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [6:0]  timerSeconds;
  logic        timerStart;

  timer_scheduler #(.N_REQ(4), .SEC_W(7)) dut (
    .CLK            (CLK),
    .resetCounter   (resetCounter),
    .req            (req),
    .req_seconds    (reqSeconds),
    .cancel         (cancel),
    .timer_finished (timerFinished),
    .grant          (grant),
    .done           (done),
    .busy           (busy),
    .timer_seconds  (timerSeconds),
    .timer_start    (timerStart)
  );

  always #5 CLK = ~CLK;

  int unsigned passCnt  = 0;
  int unsigned failCnt  = 0;
  int unsigned totalCnt = 0;

  // Reference model: who owns the timer, whether it is the start or completion cycle.
  int mOwner = -1;
  int mLast  = 3;
  int mSec   = 0;
  bit mDone  = 1'b0;
  bit mStart = 1'b0;

  int tmr = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] expGrant();
    return (mOwner < 0) ? 4'b0000 : 4'(4'b0001 << mOwner);
  endfunction

  function automatic int secOf(input int i);
    return int'(reqSeconds[i*7 +: 7]);
  endfunction

  task automatic setSec(input int i, input int v);
    reqSeconds[i*7 +: 7] = 7'(v);
  endtask

  task automatic modelStep();
    if (resetCounter) begin
      mOwner = -1; mLast = 3; mSec = 0; mDone = 1'b0; mStart = 1'b0;
    end else if (mOwner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (mLast + k) % 4;
        if (req[c]) begin
          mOwner = c;
          break;
        end
      end
      if (mOwner >= 0) begin
        mSec   = secOf(mOwner);
        mStart = (mSec != 0);
        mDone  = (mSec == 0);
      end
    end else if (mDone) begin
      mLast = mOwner; mOwner = -1; mDone = 1'b0; mSec = 0;
    end else if (mStart) begin
      mStart = 1'b0;
    end else if (timerFinished) begin
      mDone = 1'b1;
    end else if (cancel[mOwner]) begin
      mLast = mOwner; mOwner = -1; mSec = 0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    modelStep();
    #1;
    chk("grant", 32'(grant), 32'(expGrant()));
    chk("done", 32'(done), mDone ? 32'(expGrant()) : 32'd0);
    chk("busy", 32'(busy), 32'(mOwner >= 0));
    chk("timer_start", 32'(timerStart), 32'(mStart));
    chk("timer_seconds", 32'(timerSeconds), 32'(mSec));
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    chk("done_in_grant", 32'((done & ~grant) == 4'b0000), 32'd1);
  endtask

  // Tick while emulating a shared timer that finishes timer_seconds cycles after start.
  task automatic timerTick();
    tick();
    timerFinished = 1'b0;
    if (timerStart) tmr = int'(timerSeconds);
    else if (tmr > 0) tmr--;
    if (tmr == 0) begin
      timerFinished = 1'b1;
      tmr = -1;
    end
  endtask

  initial begin
    logic [3:0] order [$];
    logic [3:0] prevG;
    logic [3:0] rrExp [5];
    int dones;

    resetCounter = 1'b1; req = '0; reqSeconds = '0; cancel = '0; timerFinished = 1'b0;
    tick();
    tick();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Single request with a 5 second duration.
    resetCounter = 1'b0;
    req = 4'b0001; setSec(0, 5);
    tick();
    chk("s1_grant", 32'(grant), 32'h1);
    chk("s1_start", 32'(timerStart), 32'd1);
    chk("s1_secs", 32'(timerSeconds), 32'd5);
    req = 4'b0000;
    tick(); tick(); tick();
    timerFinished = 1'b1;
    tick();
    chk("s1_done", 32'(done), 32'h1);
    timerFinished = 1'b0;
    tick();
    chk("s1_release", 32'(grant), 32'd0);

    // All four requesting: strict rotation.
    resetCounter = 1'b1; tick(); resetCounter = 1'b0;
    for (int i = 0; i < 4; i++) setSec(i, 2);
    req = 4'b1111; prevG = '0; dones = 0; tmr = -1;
    for (int cyc = 0; cyc < 80 && order.size() < 5; cyc++) begin
      timerTick();
      if (grant != 4'b0000 && grant != prevG) order.push_back(grant);
      if (done != 4'b0000) dones++;
      prevG = grant;
    end
    req = 4'b0000;
    for (int cyc = 0; cyc < 20 && busy; cyc++) begin
      timerTick();
      if (done != 4'b0000) dones++;
    end
    timerFinished = 1'b0;
    chk("rr_grants", 32'(order.size()), 32'd5);
    chk("rr_dones", 32'(dones), 32'd5);
    rrExp[0] = 4'b0001; rrExp[1] = 4'b0010; rrExp[2] = 4'b0100; rrExp[3] = 4'b1000; rrExp[4] = 4'b0001;
    if (order.size() == 5)
      for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(rrExp[i]));

    // Cancel by owner 2; non-owner cancel and owner req drop are ignored.
    resetCounter = 1'b1; tick(); resetCounter = 1'b0;
    setSec(2, 4); setSec(3, 4);
    req = 4'b1100;
    tick();
    chk("c_grant2", 32'(grant), 32'h4);
    tick();
    cancel = 4'b0001; req = 4'b1000;
    tick();
    chk("c_nonowner", 32'(grant), 32'h4);
    cancel = 4'b0100;
    tick();
    chk("c_cleared", 32'(grant), 32'd0);
    chk("c_nodone", 32'(done), 32'd0);
    cancel = 4'b0000;
    tick();
    chk("c_next3", 32'(grant), 32'h8);
    tick();
    timerFinished = 1'b1; tick();
    timerFinished = 1'b0; req = 4'b0000; tick();

    // Cancel and finish together: finish wins.
    req = 4'b0001; setSec(0, 3);
    tick(); tick();
    cancel = 4'b0001; timerFinished = 1'b1;
    tick();
    chk("cf_done", 32'(done), 32'h1);
    cancel = 4'b0000; timerFinished = 1'b0; req = 4'b0000;
    tick();

    // Zero duration completes without touching the timer.
    req = 4'b0010; setSec(1, 0);
    tick();
    chk("z_grant", 32'(grant), 32'h2);
    chk("z_done", 32'(done), 32'h2);
    chk("z_nostart", 32'(timerStart), 32'd0);
    req = 4'b0000;
    tick();
    chk("z_idle", 32'(busy), 32'd0);

    // Reset beats a simultaneous finish; requester 0 is searched first afterwards.
    req = 4'b0001; setSec(0, 5);
    tick(); tick(); tick();
    resetCounter = 1'b1; timerFinished = 1'b1;
    tick();
    chk("r_nodone", 32'(done), 32'd0);
    chk("r_grant", 32'(grant), 32'd0);
    resetCounter = 1'b0; timerFinished = 1'b0;
    req = 4'b1001; setSec(3, 3);
    tick();
    chk("r_first0", 32'(grant), 32'h1);
    req = 4'b0000;
    tick();
    timerFinished = 1'b1; tick();
    timerFinished = 1'b0; tick();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      req = 4'($urandom);
      for (int i = 0; i < 4; i++) setSec(i, ($urandom % 5 == 0) ? 0 : int'($urandom % 8));
      cancel = ($urandom % 4 == 0) ? 4'($urandom) : 4'b0000;
      timerFinished = ($urandom % 4 == 0);
      resetCounter = ($urandom % 60 == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
